// File: rtl/i2s_receive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_receive_pkg
// Description : Shared channel encoding, word-length limits and sample width
//               for the I2S receiver and S/PDIF transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_receive_pkg;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } channel_t;

    localparam int MIN_WORD_BITS = 16;
    localparam int MAX_WORD_BITS = 63;
    localparam int SAMPLE_WIDTH  = 32;

    // Bit counter increment that sticks at the longest measurable word.
    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'(MAX_WORD_BITS)) ? v : v + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : i2s_sync_edge
// Description : Multi-flop synchronizer with rising-edge detect on the
//               synchronized output.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign q    = r_sync[SYNC_STAGES-1];
    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/i2s_receive.sv
`default_nettype none
// ============================================================================
// Module      : i2s_receive
// Description : I2S slave receiver with word-length auto-lock, frame error
//               detection and BCLK loss timeout; emits stereo sample pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_receive
    import i2s_receive_pkg::*;
#(
    parameter int DATA_BITS   = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i2s_bclk,
    input  logic                    i2s_lrclk,
    input  logic                    i2s_sdata,
    output logic [SAMPLE_WIDTH-1:0] data_left,
    output logic [SAMPLE_WIDTH-1:0] data_right,
    output logic                    sample_valid,
    output logic                    locked,
    output logic                    frame_error,
    output logic [5:0]              bits_per_channel
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic w_edge;
    logic w_lr_raw;
    logic w_sd;
    logic w_bclk_unused;
    logic w_lr_rise_unused;
    logic w_sd_rise_unused;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (i2s_bclk),
        .q    (w_bclk_unused),
        .rise (w_edge)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (i2s_lrclk),
        .q    (w_lr_raw),
        .rise (w_lr_rise_unused)
    );

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (i2s_sdata),
        .q    (w_sd),
        .rise (w_sd_rise_unused)
    );

    channel_t              w_lr;
    logic [31:0]           r_shift;
    logic [5:0]            r_bit_count;
    channel_t              r_lr_prev;
    logic [IDLE_W-1:0]     r_idle;
    logic                  r_primed;
    logic [5:0]            r_prev_len;
    logic                  r_left_ok;
    logic [SAMPLE_WIDTH-1:0] r_hold;

    logic                  w_boundary;
    logic [31:0]           w_shift_wr;
    logic [4:0]            w_bit_idx;
    logic [5:0]            w_len;
    logic [SAMPLE_WIDTH-1:0] w_word;
    logic                  w_mismatch;
    logic                  w_lock_now;
    logic                  w_timeout;

    assign w_lr       = channel_t'(w_lr_raw);
    assign w_boundary = (w_lr != r_lr_prev);
    assign w_bit_idx  = 5'd31 - r_bit_count[4:0];

    // Current edge's bit merged into the shift register; on a boundary this
    // is the trailing LSB of the word being committed.
    always_comb begin
        w_shift_wr = r_shift;
        if (r_bit_count < 6'd32) begin
            w_shift_wr[w_bit_idx] = w_sd;
        end
    end

    assign w_len      = sat_inc(r_bit_count);
    assign w_word     = SAMPLE_WIDTH'($signed(w_shift_wr[31 -: DATA_BITS]));
    assign w_mismatch = locked && (w_len != bits_per_channel);
    assign w_lock_now = locked ? !w_mismatch
                               : ((w_len == r_prev_len) && (w_len >= 6'(MIN_WORD_BITS)));
    assign w_timeout  = !w_edge && (r_idle == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift          <= '0;
            r_bit_count      <= '0;
            r_lr_prev        <= LEFT;
            r_idle           <= '0;
            r_primed         <= 1'b0;
            r_prev_len       <= '0;
            r_left_ok        <= 1'b0;
            r_hold           <= '0;
            data_left        <= '0;
            data_right       <= '0;
            sample_valid     <= 1'b0;
            locked           <= 1'b0;
            frame_error      <= 1'b0;
            bits_per_channel <= '0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (w_edge) begin
                r_idle    <= '0;
                r_lr_prev <= w_lr;
                if (!w_boundary) begin
                    r_shift     <= w_shift_wr;
                    r_bit_count <= sat_inc(r_bit_count);
                end else begin
                    r_shift     <= '0;
                    r_bit_count <= '0;
                    // The first boundary after reset/timeout only aligns to
                    // the word grid; the word before it is partial.
                    if (!r_primed) begin
                        r_primed <= 1'b1;
                    end else begin
                        r_prev_len <= w_len;
                        if (w_mismatch) begin
                            frame_error <= 1'b1;
                            locked      <= 1'b0;
                            r_left_ok   <= 1'b0;
                        end else begin
                            if (!locked && w_lock_now) begin
                                locked           <= 1'b1;
                                bits_per_channel <= w_len;
                            end
                            if (r_lr_prev == LEFT) begin
                                r_hold    <= w_word;
                                r_left_ok <= 1'b1;
                            end else if (w_lock_now && r_left_ok) begin
                                data_left    <= r_hold;
                                data_right   <= w_word;
                                sample_valid <= 1'b1;
                                r_left_ok    <= 1'b0;
                            end
                        end
                    end
                end
            end else if (w_timeout) begin
                locked      <= 1'b0;
                r_left_ok   <= 1'b0;
                r_bit_count <= '0;
                r_primed    <= 1'b0;
                r_prev_len  <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_receive.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_receive
// Description : Randomized I2S stimulus with a word-level reference model and
//               a queue-based scoreboard on sample_valid / frame_error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_receive;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i2s_bclk = 1'b0;
    logic        i2s_lrclk = 1'b0;
    logic        i2s_sdata = 1'b0;
    logic [31:0] data_left;
    logic [31:0] data_right;
    logic        sample_valid;
    logic        locked;
    logic        frame_error;
    logic [5:0]  bits_per_channel;

    i2s_receive dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i2s_bclk        (i2s_bclk),
        .i2s_lrclk       (i2s_lrclk),
        .i2s_sdata       (i2s_sdata),
        .data_left       (data_left),
        .data_right      (data_right),
        .sample_valid    (sample_valid),
        .locked          (locked),
        .frame_error     (frame_error),
        .bits_per_channel(bits_per_channel)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ch;
        int          len;
        logic [63:0] bits;   // MSB-first, bit 63 transmitted first
    } word_t;

    word_t       seg[$];
    logic [63:0] exp_q[$];
    int          exp_err = 0;
    int          n_vec = 0;
    int          n_miss = 0;

    // Reference model state (word-level)
    bit          m_primed;
    int          m_prev_len;
    bit          m_locked;
    int          m_bpc;
    bit          m_left_ok;
    logic [31:0] m_hold;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_primed = 0; m_prev_len = 0; m_locked = 0; m_bpc = 0; m_left_ok = 0; m_hold = '0;
    endfunction

    function automatic void model_timeout();
        m_primed = 0; m_prev_len = 0; m_locked = 0; m_left_ok = 0;
    endfunction

    // Audio value as received: first 32 bits left-justified, top 24 kept,
    // sign-extended to 32.
    function automatic logic [31:0] word_value(input word_t w);
        logic [31:0] sh = '0;
        for (int k = 0; k < w.len && k < 32; k++) sh[31-k] = w.bits[63-k];
        return {{8{sh[31]}}, sh[31:8]};
    endfunction

    function automatic void model_commit(input word_t w);
        logic [31:0] v = word_value(w);
        bit err = 0;
        if (!m_primed) begin
            m_primed = 1;
            return;
        end
        if (m_locked && w.len != m_bpc) begin
            err = 1; m_locked = 0; m_left_ok = 0; exp_err++;
        end else if (!m_locked && w.len == m_prev_len && w.len >= 16) begin
            m_locked = 1; m_bpc = w.len;
        end
        m_prev_len = w.len;
        if (!err) begin
            if (w.ch == 1'b0) begin
                m_hold = v; m_left_ok = 1;
            end else if (m_locked && m_left_ok) begin
                exp_q.push_back({m_hold, v});
                m_left_ok = 0;
            end
        end
    endfunction

    // Model then drive the current segment; the last word only closes the
    // previous one. abort_at >= 0 pulses reset before that BCLK period.
    task automatic run_segment(input int abort_at);
        int np = 0;
        int p = 0;
        bit lr_a[];
        bit sd_a[];
        foreach (seg[i]) np += seg[i].len;
        lr_a = new[np];
        sd_a = new[np];
        foreach (sd_a[i]) sd_a[i] = 0;
        foreach (seg[i]) begin
            if (i > 0 && (abort_at < 0 || p < abort_at)) model_commit(seg[i-1]);
            for (int k = 0; k < seg[i].len; k++) begin
                lr_a[p+k] = seg[i].ch;
                if (p + 1 + k < np) sd_a[p+1+k] = seg[i].bits[63-k];
            end
            p += seg[i].len;
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < np; i++) begin
            if (i == abort_at) begin
                #40;
                rst_n = 1'b0;
                #1;
                chk("rst_mid_left", data_left, 0);
                chk("rst_mid_right", data_right, 0);
                chk("rst_mid_locked", locked, 0);
                chk("rst_mid_bpc", bits_per_channel, 0);
                chk("rst_mid_valid", sample_valid, 0);
                chk("rst_mid_ferr", frame_error, 0);
                #30;
                rst_n = 1'b1;
                model_reset();
                break;
            end
            i2s_lrclk = lr_a[i];
            i2s_sdata = sd_a[i];
            #40 i2s_bclk = 1'b1;
            #40 i2s_bclk = 1'b0;
        end
        seg.delete();
    endtask

    function automatic void add_frames(input int n, input int len, input logic [63:0] l, input logic [63:0] r, input bit rnd);
        for (int f = 0; f < n; f++) begin
            seg.push_back('{1'b0, len, rnd ? {$urandom(), $urandom()} : l});
            seg.push_back('{1'b1, len, rnd ? {$urandom(), $urandom()} : r});
        end
    endfunction

    task automatic stall();
        repeat (240) @(posedge clk);
        chk("stall_locked_before", locked, m_locked);
        repeat (35) @(posedge clk);
        chk("stall_locked_after", locked, 0);
        repeat (30) @(posedge clk);
        model_timeout();
        chk("stall_no_ferr", exp_err, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_sample: got %h/%h expected none", data_left, data_right);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("sample_left", data_left, e[63:32]);
                    chk("sample_right", data_right, e[31:0]);
                end
            end
            if (frame_error) begin
                n_vec++;
                if (exp_err == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_frame_error: got 1 expected 0");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_left", data_left, 0);
        chk("reset_right", data_right, 0);
        chk("reset_valid", sample_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_ferr", frame_error, 0);
        chk("reset_bpc", bits_per_channel, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // 24-bit audio in 32-bit slots
        add_frames(4, 32, {24'h123456, 40'h0}, {24'hABCDEF, 40'h0}, 0);
        seg.push_back('{1'b0, 2, 64'h0});
        run_segment(-1);
        repeat (10) @(posedge clk);
        chk("fix_left", data_left, 32'h00123456);
        chk("fix_right", data_right, 32'hFFABCDEF);
        chk("fix_locked", locked, 1);
        chk("fix_bpc", bits_per_channel, 32);
        stall();

        // Short left word while locked
        add_frames(2, 32, 0, 0, 1);
        seg.push_back('{1'b0, 31, {$urandom(), $urandom()}});
        seg.push_back('{1'b1, 32, {$urandom(), $urandom()}});
        add_frames(3, 32, 0, 0, 1);
        seg.push_back('{1'b0, 2, 64'h0});
        run_segment(-1);
        repeat (10) @(posedge clk);
        chk("err_seen", exp_err, 0);
        chk("err_relocked", locked, 1);
        chk("err_bpc", bits_per_channel, 32);
        stall();

        // 16-bit words
        add_frames(4, 16, {16'h8001, 48'h0}, 0, 0);
        foreach (seg[i]) if (seg[i].ch) seg[i].bits = {$urandom(), $urandom()};
        seg.push_back('{1'b0, 2, 64'h0});
        run_segment(-1);
        repeat (10) @(posedge clk);
        chk("w16_left", data_left, 32'hFF800100);
        chk("w16_bpc", bits_per_channel, 16);
        stall();

        // Random word lengths and data
        for (int s = 0; s < 4; s++) begin
            add_frames(4, int'($urandom_range(12, 60)), 0, 0, 1);
            seg.push_back('{1'b0, 2, 64'h0});
            run_segment(-1);
            repeat (10) @(posedge clk);
            chk("rnd_locked", locked, m_locked);
            chk("rnd_bpc", bits_per_channel, m_bpc);
            stall();
        end

        // Reset mid right word of the third frame, then relock
        add_frames(4, 32, 0, 0, 1);
        run_segment(32 * 5 + 10);
        add_frames(4, 32, 0, 0, 1);
        seg.push_back('{1'b0, 2, 64'h0});
        run_segment(-1);
        repeat (10) @(posedge clk);
        chk("rst_relocked", locked, 1);

        repeat (20) @(posedge clk);
        chk("sb_queue_empty", exp_q.size(), 0);
        chk("sb_ferr_pending", exp_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
